hls_deadlock_multi_monitor: RTL and testbench

Parametrised deadlock monitor for HLS-generated top-level instances such as the RK4_LBE_B_64 kernels. It watches N AXI-Stream block flags and M sub-instance idle/block flags and debounces the block condition over a programmable persistence window. It reports a sticky or live `block` flag together with the first offending channel/instance index and a saturating stall-cycle count. It sits beside the kernel top and feeds the simulation/debug deadlock reporter.

---
 rtl/hls_deadlock_multi_monitor.sv | 117 +++++++++++
 tb/tb_hls_deadlock_multi_monitor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hls_deadlock_multi_monitor.sv
// Deadlock monitor for HLS kernel tops: debounces stream/instance block
// flags and latches the first offending source plus a stall counter.
module hls_deadlock_multi_monitor #(
   parameter int NUM_AXIS  = 1,
   parameter int NUM_INST  = 1,
   parameter int THRESHOLD = 1,
   parameter bit STICKY    = 1'b1,
   localparam int AIDX_W = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1,
   localparam int IIDX_W = (NUM_INST > 1) ? $clog2(NUM_INST) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_AXIS-1:0] axis_block_sigs,
   input  logic [NUM_INST-1:0] inst_idle_sigs,
   input  logic [NUM_INST-1:0] inst_block_sigs,
   input  logic                clear,
   output logic                block,
   output logic                arming,
   output logic [1:0]          block_src,
   output logic [AIDX_W-1:0]   first_axis_idx,
   output logic [IIDX_W-1:0]   first_inst_idx,
   output logic [15:0]         stall_cycles
);

   localparam int CNT_W = $clog2(THRESHOLD + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESHOLD - 1);

   typedef enum logic [1:0] {
      IDLE,
      ARMING,
      BLOCKED
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              axis_cand;
   logic              inst_cand;
   logic              cand;
   logic [AIDX_W-1:0] axis_low;
   logic [IIDX_W-1:0] inst_low;

   assign axis_cand = |axis_block_sigs;
   assign inst_cand = (&(inst_idle_sigs | inst_block_sigs))
                    & (|inst_block_sigs);
   assign cand      = axis_cand | inst_cand;

   // Scan from the top so the lowest set bit wins.
   always_comb begin
      axis_low = '0;
      for (int i = NUM_AXIS - 1; i >= 0; i--)
         if (axis_block_sigs[i]) axis_low = AIDX_W'(i);
   end

   always_comb begin
      inst_low = '0;
      for (int i = NUM_INST - 1; i >= 0; i--)
         if (inst_block_sigs[i]) inst_low = IIDX_W'(i);
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:
            if (cand)
               state_nxt = (THRESHOLD == 1) ? BLOCKED : ARMING;
         ARMING:
            if (!cand)
               state_nxt = IDLE;
            else if (cnt == CNT_LAST)
               state_nxt = BLOCKED;
         BLOCKED:
            if (!STICKY && !cand)
               state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
      if (clear) state_nxt = IDLE;
   end

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         state          <= IDLE;
         cnt            <= '0;
         stall_cycles   <= '0;
         block_src      <= '0;
         first_axis_idx <= '0;
         first_inst_idx <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE:
               if (cand) begin
                  block_src      <= {inst_cand, axis_cand};
                  first_axis_idx <= axis_low;
                  first_inst_idx <= inst_low;
                  stall_cycles   <= '0;
                  cnt <= (THRESHOLD == 1) ? '0 : CNT_W'(1);
               end
            ARMING:
               if (!cand || cnt == CNT_LAST)
                  cnt <= '0;
               else
                  cnt <= cnt + 1'b1;
            BLOCKED:
               if (stall_cycles != 16'hFFFF)
                  stall_cycles <= stall_cycles + 16'd1;
            default:
               cnt <= '0;
         endcase
      end
   end

   assign block  = (state == BLOCKED);
   assign arming = (state == ARMING);

endmodule

// File: tb/tb_hls_deadlock_multi_monitor.sv
// Scoreboard bench: two monitor instances (THRESHOLD=1 live, THRESHOLD=4
// sticky) checked against hand-computed per-cycle expectations.
module tb_hls_deadlock_multi_monitor;

  typedef struct {
    int          cyc;
    int          dut;
    logic        blk;
    logic        arm;
    logic [1:0]  src;
    logic [1:0]  aidx;
    logic [1:0]  iidx;
    int          stall;
    string       name;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   n_exp = 0;
  exp_t q[$];

  logic [3:0]  a_axis = '0, b_axis = '0;
  logic [2:0]  a_idle = '0, b_idle = '0;
  logic [2:0]  a_blk  = '0, b_blk  = '0;
  logic        a_clr  = 1'b0, b_clr = 1'b0;
  logic        a_block, a_arming, b_block, b_arming;
  logic [1:0]  a_src, b_src, a_aidx, b_aidx, a_iidx, b_iidx;
  logic [15:0] a_stall, b_stall;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  hls_deadlock_multi_monitor #(
    .NUM_AXIS(4), .NUM_INST(3), .THRESHOLD(1), .STICKY(1'b0)
  ) u_a (
    .clock(clock), .reset(reset),
    .axis_block_sigs(a_axis), .inst_idle_sigs(a_idle),
    .inst_block_sigs(a_blk), .clear(a_clr),
    .block(a_block), .arming(a_arming), .block_src(a_src),
    .first_axis_idx(a_aidx), .first_inst_idx(a_iidx),
    .stall_cycles(a_stall)
  );

  hls_deadlock_multi_monitor #(
    .NUM_AXIS(4), .NUM_INST(3), .THRESHOLD(4), .STICKY(1'b1)
  ) u_b (
    .clock(clock), .reset(reset),
    .axis_block_sigs(b_axis), .inst_idle_sigs(b_idle),
    .inst_block_sigs(b_blk), .clear(b_clr),
    .block(b_block), .arming(b_arming), .block_src(b_src),
    .first_axis_idx(b_aidx), .first_inst_idx(b_iidx),
    .stall_cycles(b_stall)
  );

  task automatic ex(input int c, input int d, input logic bl,
                    input logic ar, input logic [1:0] s,
                    input logic [1:0] ai, input logic [1:0] ii,
                    input int st, input string nm);
    exp_t e;
    e.cyc = c; e.dut = d; e.blk = bl; e.arm = ar; e.src = s;
    e.aidx = ai; e.iidx = ii; e.stall = st; e.name = nm;
    q.push_back(e);
    n_exp++;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic        bl, ar;
      logic [1:0]  s, ai, ii;
      logic [15:0] st;
      logic        ok;
      e = q.pop_front();
      if (e.dut == 0) begin
        bl = a_block; ar = a_arming; s = a_src;
        ai = a_aidx; ii = a_iidx; st = a_stall;
      end else begin
        bl = b_block; ar = b_arming; s = b_src;
        ai = b_aidx; ii = b_iidx; st = b_stall;
      end
      total++;
      ok = (e.cyc == cyc) && bl === e.blk && ar === e.arm
        && s === e.src && ai === e.aidx && ii === e.iidx
        && (e.stall < 0 || st === 16'(e.stall));
      if (!ok) begin
        bad++;
        $display("FAIL %s cyc=%0d: got blk=%b arm=%b src=%b ai=%0d ii=%0d st=%0d want blk=%b arm=%b src=%b ai=%0d ii=%0d st=%0d",
                 e.name, cyc, bl, ar, s, ai, ii, st,
                 e.blk, e.arm, e.src, e.aidx, e.iidx, e.stall);
      end
    end
  end

  initial begin
    ex(2, 0, 0, 0, 2'b00, 0, 0, 0, "a_reset");
    ex(2, 1, 0, 0, 2'b00, 0, 0, 0, "b_reset");
    wait_cyc(2);
    reset = 1'b0;

    ex(11, 0, 1, 0, 2'b01, 2, 0, 0, "a_th1_block");
    ex(12, 0, 1, 0, 2'b01, 2, 0, 1, "a_stall_1");
    ex(13, 0, 0, 0, 2'b01, 2, 0, -1, "a_live_drop");
    wait_cyc(10);
    a_axis = 4'b0100;
    wait_cyc(12);
    a_axis = 4'b0000;

    ex(21, 1, 0, 1, 2'b10, 0, 1, 0, "b_arm_first");
    ex(23, 1, 0, 1, 2'b10, 0, 1, 0, "b_arm_last");
    ex(24, 1, 1, 0, 2'b10, 0, 1, 0, "b_th4_block");
    ex(25, 1, 1, 0, 2'b10, 0, 1, 1, "b_stall_1");
    ex(27, 1, 1, 0, 2'b10, 0, 1, 3, "b_sticky_hold");
    ex(29, 1, 0, 0, 2'b00, 0, 0, 0, "b_clear");
    ex(30, 1, 0, 1, 2'b01, 3, 0, 0, "b_rearm");
    ex(33, 1, 0, 0, 2'b00, 0, 0, 0, "b_clear_wins");
    ex(34, 1, 0, 1, 2'b01, 3, 0, 0, "b_rearm2");
    ex(35, 1, 0, 0, 2'b01, 3, 0, 0, "b_idle_retain");
    wait_cyc(20);
    b_idle = 3'b101;
    b_blk  = 3'b010;
    wait_cyc(25);
    b_idle = 3'b000;
    b_blk  = 3'b000;
    wait_cyc(28);
    b_axis = 4'b1000;
    b_clr  = 1'b1;
    wait_cyc(29);
    b_clr  = 1'b0;
    wait_cyc(32);
    b_clr  = 1'b1;
    wait_cyc(33);
    b_clr  = 1'b0;
    wait_cyc(34);
    b_axis = 4'b0000;

    ex(41, 1, 0, 1, 2'b01, 1, 0, 0, "b_burst1");
    ex(44, 1, 0, 0, 2'b01, 1, 0, 0, "b_gap");
    ex(45, 1, 0, 1, 2'b01, 0, 0, 0, "b_recapture");
    ex(47, 1, 0, 1, 2'b01, 0, 0, 0, "b_frozen");
    ex(48, 1, 1, 0, 2'b01, 0, 0, 0, "b_burst_block");
    wait_cyc(40);
    b_axis = 4'b0010;
    wait_cyc(43);
    b_axis = 4'b0000;
    wait_cyc(44);
    b_axis = 4'b0001;
    wait_cyc(45);
    b_axis = 4'b1100;

    ex(51, 1, 0, 0, 2'b00, 0, 0, 0, "b_clr_idle");
    ex(53, 1, 0, 0, 2'b00, 0, 0, 0, "b_no_arm");
    wait_cyc(50);
    b_axis = 4'b0000;
    b_idle = 3'b001;
    b_blk  = 3'b010;
    b_clr  = 1'b1;
    wait_cyc(51);
    b_clr  = 1'b0;

    ex(62, 0, 1, 0, 2'b01, 0, 0, 1, "a_pre_reset");
    ex(64, 0, 0, 0, 2'b00, 0, 0, 0, "a_reset_clr");
    ex(64, 1, 0, 0, 2'b00, 0, 0, 0, "b_reset_mid");
    ex(65, 0, 1, 0, 2'b01, 0, 0, 0, "a_post_reset");
    ex(65, 1, 0, 1, 2'b01, 2, 0, 0, "b_post_reset");
    wait_cyc(60);
    a_axis = 4'b0001;
    b_idle = 3'b000;
    b_blk  = 3'b000;
    wait_cyc(63);
    reset  = 1'b1;
    a_clr  = 1'b1;
    b_axis = 4'b0100;
    wait_cyc(64);
    reset  = 1'b0;
    a_clr  = 1'b0;
    wait_cyc(65);
    b_axis = 4'b0000;

    ex(65599, 0, 1, 0, 2'b01, 0, 0, 65534, "a_sat_pre");
    ex(65600, 0, 1, 0, 2'b01, 0, 0, 65535, "a_sat");
    ex(70100, 0, 1, 0, 2'b01, 0, 0, 65535, "a_sat_hold");
    ex(70101, 0, 0, 0, 2'b01, 0, 0, 65535, "a_sat_drop");
    wait_cyc(70100);
    a_axis = 4'b0000;

    wait_cyc(70105);
    @(negedge clock);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL %s: got unchecked want cycle %0d", e.name, e.cyc);
    end
    if (total != n_exp) begin
      bad++;
      $display("FAIL count: total=%0d want %0d", total, n_exp);
    end
    if (bad != 0)
      $display("FAIL: bad=%0d", bad);
    else
      $display("PASS");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
